// File: rtl/adder_subtractor.sv
// Purpose : registered NBITS-wide add/subtract with carry, overflow, zero and negative flags.
// Latency : 1 cycle from i_valid to o_valid; back-to-back operations are accepted every cycle.
// Backpres: none -- there is no ready; the consumer must take every o_valid pulse.
module adder_subtractor #(
  parameter int NBITS = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_ACC,
  input  logic [NBITS-1:0] i_SelB,
  input  logic             i_Op,
  input  logic             i_valid,
  output logic [NBITS-1:0] o_Result,
  output logic             o_valid,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  // B is inverted on subtract and the +1 enters as carry-in, so one adder
  // serves both operations and bit NBITS is carry (add) or no-borrow (sub).
  logic [NBITS-1:0] operand_b;
  logic [NBITS:0]   sum;
  logic             overflow_next;

  // Shared adder datapath and signed-overflow detection.
  always_comb begin
    operand_b     = i_Op ? ~i_SelB : i_SelB;
    sum           = {1'b0, i_ACC} + {1'b0, operand_b} + {{NBITS{1'b0}}, i_Op};
    // Overflow when both adder inputs share a sign that the result lacks;
    // with B inverted this covers "A and B differ in sign" on subtract.
    overflow_next = (i_ACC[NBITS-1] == operand_b[NBITS-1]) &&
                    (sum[NBITS-1] != i_ACC[NBITS-1]);
  end

  // Valid strobe follows i_valid by one cycle; reset drops any in-flight op.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
    end
  end

  // Result and carry/overflow are captured only on valid cycles, held otherwise.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_Result   <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_valid) begin
      o_Result   <= sum[NBITS-1:0];
      o_carry    <= sum[NBITS];
      o_overflow <= overflow_next;
    end
  end

  // Zero and negative come straight off the result register, so they track
  // it exactly, including the reset value (zero = 1, negative = 0).
  always_comb begin
    o_zero     = (o_Result == '0);
    o_negative = o_Result[NBITS-1];
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// Scoreboarded random/directed bench for adder_subtractor (NBITS = 16).
// Driver pushes model results into a queue; a negedge monitor pops and compares.
// Outputs between results are checked for hold, and reset values are checked directly.
module tb_adder_subtractor;

  logic        i_clock;
  logic        i_reset;
  logic [15:0] i_ACC;
  logic [15:0] i_SelB;
  logic        i_Op;
  logic        i_valid;
  logic [15:0] o_Result;
  logic        o_valid;
  logic        o_carry;
  logic        o_overflow;
  logic        o_zero;
  logic        o_negative;

  adder_subtractor #(.NBITS(16)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_ACC      (i_ACC),
    .i_SelB     (i_SelB),
    .i_Op       (i_Op),
    .i_valid    (i_valid),
    .o_Result   (o_Result),
    .o_valid    (o_valid),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_zero     (o_zero),
    .o_negative (o_negative)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  exp_t rst_val;
  int   errors = 0;
  int   checks = 0;
  bit   in_reset;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic op);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (!op) begin
      r   = ua + ub;
      e.c = (r >= 65536);
      sr  = sa + sb;
    end else begin
      r   = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sb;
    end
    e.res = r[15:0];
    e.v   = (sr > 32767) || (sr < -32768);
    e.z   = (e.res == 16'd0);
    e.n   = e.res[15];
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(string tag, exp_t e);
    check({tag, "_result"},   o_Result,   e.res);
    check({tag, "_carry"},    o_carry,    e.c);
    check({tag, "_overflow"}, o_overflow, e.v);
    check({tag, "_zero"},     o_zero,     e.z);
    check({tag, "_negative"}, o_negative, e.n);
  endtask

  task automatic issue(logic [15:0] a, logic [15:0] b, logic op, logic v);
    @(posedge i_clock);
    #1;
    i_ACC   = a;
    i_SelB  = b;
    i_Op    = op;
    i_valid = v;
    if (v) sb_q.push_back(model(a, b, op));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: pop on every o_valid, otherwise outputs must hold the last result.
  initial begin
    forever begin
      @(negedge i_clock);
      if (in_reset) begin
        check("reset_valid", o_valid, 1'b0);
        check_outputs("reset_hold", rst_val);
      end else if (o_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", o_valid, 1'b0);
        end else begin
          last = sb_q.pop_front();
          check_outputs("res", last);
        end
      end else begin
        check_outputs("hold", last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_val  = '{res: 16'h0000, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0};
    last     = rst_val;
    in_reset = 1'b1;
    i_reset  = 1'b0;
    i_ACC    = 16'h0;
    i_SelB   = 16'h0;
    i_Op     = 1'b0;
    i_valid  = 1'b1;   // asserted during reset: must be discarded
    #12;
    check("init_valid", o_valid, 1'b0);
    check_outputs("init", rst_val);
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    @(negedge i_clock);
    #1;
    i_reset  = 1'b1;
    in_reset = 1'b0;

    // Directed corner cases.
    issue(16'd15,    16'd15, 1'b1, 1'b1);
    issue(16'd15,    16'd15, 1'b0, 1'b1);
    issue(16'h7FFF,  16'd1,  1'b0, 1'b1);
    issue(16'h0000,  16'd1,  1'b1, 1'b1);
    issue(16'hFFFF,  16'd1,  1'b0, 1'b1);
    issue(16'h0,     16'h0,  1'b0, 1'b0);
    issue(16'h1234,  16'h5,  1'b1, 1'b0);
    issue(16'hABCD,  16'h7,  1'b0, 1'b0);
    issue(16'h8000,  16'd1,  1'b1, 1'b1);
    issue(16'h8000,  16'h8000, 1'b0, 1'b1);

    // Random stream with gaps and per-cycle op changes.
    for (int i = 0; i < 300; i++)
      issue(pick(), pick(), 1'($urandom), ($urandom_range(0, 3) != 0));

    // Mid-stream reset without a clock edge: in-flight op is abandoned.
    issue(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge i_clock);
    #1;
    i_reset  = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_reset_valid", o_valid, 1'b0);
    check_outputs("async_reset", rst_val);
    sb_q.delete();
    last = rst_val;
    repeat (3) @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    @(negedge i_clock);
    #1;
    i_reset  = 1'b1;
    in_reset = 1'b0;

    issue(16'd100, 16'd58, 1'b1, 1'b1);
    issue(16'd0,   16'd0,  1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      issue(pick(), pick(), 1'($urandom), ($urandom_range(0, 3) != 0));
    issue(16'h0, 16'h0, 1'b0, 1'b0);

    repeat (4) @(posedge i_clock);
    check("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 SHALL have parameter NBITS, default 16, giving the data width of operands and result.
REQ-002 SHALL have port i_clock, input, 1, the single clock, rising edge active.
REQ-003 SHALL have port i_reset, input, 1, the reset, asynchronous and active-low.
REQ-004 SHALL have port i_ACC, input, NBITS, accumulator operand A.
REQ-005 SHALL have port i_SelB, input, NBITS, selected operand B.
REQ-006 SHALL have port i_Op, input, 1, operation select: 0 = add, 1 = subtract.
REQ-007 SHALL have port i_valid, input, 1, operands and op are valid this cycle.
REQ-008 SHALL have port o_Result, output, NBITS, registered result.
REQ-009 SHALL have port o_valid, output, 1, o_Result and flags hold a new result.
REQ-010 SHALL have port o_carry, output, 1, carry out on add; no-borrow on subtract (A >= B unsigned).
REQ-011 SHALL have port o_overflow, output, 1, two's-complement signed overflow.
REQ-012 SHALL have port o_zero, output, 1, o_Result equals 0.
REQ-013 SHALL have port o_negative, output, 1, MSB of o_Result.

Function
REQ-014 SHALL compute A + B when i_Op = 0 and A - B (A + ~B + 1) when i_Op = 1, modulo 2^NBITS.
REQ-015 SHALL capture the result and all flags on the rising i_clock edge where i_valid = 1, giving 1-cycle latency.
REQ-016 SHALL hold o_Result and flags unchanged on cycles where i_valid = 0.
REQ-017 SHALL drive o_valid = 1 for exactly the cycle after each i_valid = 1 cycle, 0 otherwise; back-to-back i_valid produces back-to-back o_valid.
REQ-018 SHALL set o_carry to bit NBITS of the (NBITS+1)-bit internal sum, including the +1 injected on subtract.
REQ-019 SHALL set o_overflow on add when A and B share a sign and the result sign differs; on subtract when A and B differ in sign and the result sign differs from A.
REQ-020 SHALL derive o_zero and o_negative from the registered result value, not from unregistered inputs.
REQ-021 SHALL wrap silently on overflow/underflow; no saturation.
REQ-022 SHALL treat operands as raw bit vectors; signed/unsigned interpretation is left to the consumer via o_carry/o_overflow.
REQ-023 SHALL contain no state other than the output registers; i_Op may change every cycle.

Reset
REQ-024 SHALL, while i_reset = 0, asynchronously force o_Result = 0, o_valid = 0, o_carry = 0, o_overflow = 0, o_negative = 0, o_zero = 1.
REQ-025 SHALL resume normal capture on the first rising edge after i_reset returns to 1; an i_valid asserted during reset is discarded.
REQ-026 SHALL abandon an in-flight result when reset asserts mid-operation; no o_valid pulse after reset release for it.

Verification (NBITS = 16)
REQ-027 SHALL pass: A = 15, B = 15, Op = 1, valid -> next cycle o_Result = 0, o_zero = 1, o_carry = 1, o_overflow = 0, o_valid = 1.
REQ-028 SHALL pass: A = 15, B = 15, Op = 0, valid -> o_Result = 30, o_zero = 0, o_carry = 0, o_negative = 0.
REQ-029 SHALL pass: A = 0x7FFF, B = 1, Op = 0 -> o_Result = 0x8000, o_overflow = 1, o_negative = 1, o_carry = 0.
REQ-030 SHALL pass: A = 0, B = 1, Op = 1 -> o_Result = 0xFFFF, o_carry = 0 (borrow), o_negative = 1, o_overflow = 0.
REQ-031 SHALL pass: A = 0xFFFF, B = 1, Op = 0 -> o_Result = 0, o_carry = 1, o_zero = 1; then i_valid = 0 for 3 cycles -> outputs held, o_valid = 0.
REQ-032 SHALL pass: i_reset pulled low mid-stream without a clock edge -> outputs immediately at reset values; first valid after release gives correct result one cycle later.
